// File: rtl/ei_tdp_ram_model.sv
// Behavioural true dual-port RAM responder. It clears itself after reset,
// serves read-first registered reads on ports A and B, and flags same-address write collisions.
//
// Ports:
//   clk, reset (async, active-high)
//   we_x, re_x, addr_x, data_x  -> per-port request (x = a, b)
//   out_x, rvalid_x             <- registered read data and its valid strobe
//   wcoll                       <- one-cycle pulse: both ports wrote one address
//   init_done                   <- array clear complete, requests accepted
module ei_tdp_ram_model #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we_a,
    input  logic                  re_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] data_a,
    output logic [DATA_WIDTH-1:0] out_a,
    output logic                  rvalid_a,
    input  logic                  we_b,
    input  logic                  re_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] data_b,
    output logic [DATA_WIDTH-1:0] out_b,
    output logic                  rvalid_b,
    output logic                  wcoll,
    output logic                  init_done
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE  = ADDR_WIDTH'(1);

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   clr_addr;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // Array has no reset of its own; the CLEAR sweep zeroes it instead.
    // Port A is written last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_addr] <= '0;
        end else begin
            if (we_b) mem[addr_b] <= data_b;
            if (we_a) mem[addr_a] <= data_a;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= CLEAR;
            clr_addr  <= '0;
            init_done <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            rvalid_a  <= 1'b0;
            rvalid_b  <= 1'b0;
            wcoll     <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    rvalid_a <= 1'b0;
                    rvalid_b <= 1'b0;
                    wcoll    <= 1'b0;
                    if (clr_addr == LAST) begin
                        state     <= RUN;
                        init_done <= 1'b1;
                    end else begin
                        clr_addr <= clr_addr + ONE;
                    end
                end
                RUN: begin
                    // Reads sample mem before this edge's writes land (read-first).
                    if (re_a) out_a <= mem[addr_a];
                    if (re_b) out_b <= mem[addr_b];
                    rvalid_a <= re_a;
                    rvalid_b <= re_b;
                    wcoll    <= we_a && we_b && (addr_a == addr_b);
                end
                default: state <= CLEAR;
            endcase
        end
    end

endmodule
